// File: rtl/pmm_dispatcher.sv
// pmm_dispatcher: round-robin job streaming to pattern-matching modules with delayed result collection.
module pmm_dispatcher #(
  parameter int NUM_PMM   = 4,
  parameter int RES_DELAY = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [63:0]             in_data,
  input  logic [15:0]             in_control,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [NUM_PMM*64-1:0]   pmm_data,
  output logic [NUM_PMM*16-1:0]   pmm_control,
  output logic [NUM_PMM-1:0]      pmm_valid,
  input  logic [NUM_PMM-1:0]      pmm_ready,
  input  logic [NUM_PMM-1:0]      pmm_accepted,
  output logic                    res_valid,
  output logic [2:0]              res_id,
  output logic                    res_match,
  input  logic                    res_ready,
  output logic [15:0]             jobs_done
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_nxt;
  logic [2:0] sel, sel_nxt, rr_ptr, pick, rpick;
  logic [3:0] j;
  logic found, rfound, xfer, done, res_hs;
  logic [7:0] elig, rdy, ripe, acc;
  logic [NUM_PMM-1:0] pending, ripe_v;
  logic [3:0] cnt [NUM_PMM];
  // Widen per-module vectors to 8 bits so 3-bit indices never fall out of range.
  assign rdy = 8'(pmm_ready);
  assign elig = 8'(pmm_ready & ~pending);
  assign ripe = 8'(ripe_v);
  assign acc = 8'(pmm_accepted);
  assign xfer = in_valid & in_ready;
  assign done = xfer & in_last;
  assign res_hs = res_valid & res_ready;
  always_comb begin
    ripe_v = '0;
    for (int i = 0; i < NUM_PMM; i++) ripe_v[i] = pending[i] && cnt[i] == 4'd0;
  end
  // Scan offsets from highest to lowest so the nearest eligible index after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    pick = '0;
    j = '0;
    for (int i = NUM_PMM - 1; i >= 0; i--) begin
      j = {1'b0, rr_ptr} + 4'(i);
      if (j >= 4'(NUM_PMM)) j = j - 4'(NUM_PMM);
      if (elig[j[2:0]]) begin
        found = 1'b1;
        pick = j[2:0];
      end
    end
  end
  always_comb begin
    rfound = 1'b0;
    rpick = '0;
    for (int i = NUM_PMM - 1; i >= 0; i--)
      if (ripe[i]) begin
        rfound = 1'b1;
        rpick = 3'(i);
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel <= '0;
    end else begin
      state <= state_nxt;
      sel <= sel_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    sel_nxt = sel;
    if (state == IDLE) begin
      state_nxt = found ? STREAM : IDLE;
      sel_nxt = found ? pick : sel;
    end else if (done) begin
      state_nxt = IDLE;
    end
  end
  always_comb in_ready = (state == STREAM) && rdy[sel];
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      pending <= '0;
      jobs_done <= '0;
      pmm_valid <= '0;
      pmm_data <= '0;
      pmm_control <= '0;
      res_valid <= 1'b0;
      res_id <= '0;
      res_match <= 1'b0;
      for (int k = 0; k < NUM_PMM; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_PMM; k++) begin
        pmm_valid[k] <= xfer && sel == 3'(k);
        if (xfer && sel == 3'(k)) begin
          pmm_data[k*64 +: 64] <= in_data;
          pmm_control[k*16 +: 16] <= in_control;
        end
        if (done && sel == 3'(k)) cnt[k] <= 4'(RES_DELAY);
        else if (cnt[k] != 4'd0) cnt[k] <= cnt[k] - 4'd1;
        pending[k] <= (pending[k] && !(res_hs && res_id == 3'(k))) || (done && sel == 3'(k));
      end
      if (done) begin
        rr_ptr <= (sel == 3'(NUM_PMM - 1)) ? 3'd0 : sel + 3'd1;
        jobs_done <= jobs_done + 16'd1;
      end
      if (!res_valid) begin
        res_valid <= rfound;
        if (rfound) begin
          res_id <= rpick;
          res_match <= acc[rpick];
        end
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pmm_dispatcher.sv
// tb_pmm_dispatcher: table-driven and directed checks of dispatch, stall, result and reset behaviour.
module tb_pmm_dispatcher;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [15:0] in_control = '0;
  logic in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [255:0] pmm_data;
  logic [63:0] pmm_control;
  logic [3:0] pmm_valid;
  logic [3:0] pmm_ready = 4'hf, pmm_accepted = 4'h0;
  logic res_valid, res_match, res_ready = 1'b0;
  logic [2:0] res_id;
  logic [15:0] jobs_done;
  int checks = 0, failures = 0;

  pmm_dispatcher #(.NUM_PMM(4), .RES_DELAY(3)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_control(in_control),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .pmm_data(pmm_data), .pmm_control(pmm_control), .pmm_valid(pmm_valid),
    .pmm_ready(pmm_ready), .pmm_accepted(pmm_accepted),
    .res_valid(res_valid), .res_id(res_id), .res_match(res_match),
    .res_ready(res_ready), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic iv, il, rr;
    logic ir;
    logic [3:0] pv;
    logic rv;
    logic [2:0] id;
    logic [15:0] jobs;
  } vec_t;
  vec_t v [17];

  function automatic logic [63:0] dat(input int i);
    return 64'hDA7A_0000_0000_0000 | 64'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    res_ready = 1'b0;
    step;
    step;
    reset = 1'b0;
  endtask

  task automatic xfer(input logic [63:0] d, input logic last, input int m);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_control = d[15:0];
    in_last = last;
    #1;
    while (!in_ready && n < 40) begin
      step;
      #1;
      n++;
    end
    chk("xfer_ready", 64'(in_ready), 64'd1);
    step;
    in_valid = 1'b0;
    in_last = 1'b0;
    #1;
    chk("xfer_valid", 64'(pmm_valid), 64'd1 << m);
    chk("xfer_data", pmm_data[m*64 +: 64], d);
    chk("xfer_ctrl", 64'(pmm_control[m*16 +: 16]), 64'(d[15:0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    v[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 16'd0};
    v[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 16'd0};
    v[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 3'd0, 16'd0};
    v[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd0, 16'd1};
    v[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 16'd1};
    v[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0, 3'd0, 16'd1};
    v[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 3'd0, 16'd2};
    v[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 3'd0, 16'd2};
    v[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 3'd0, 16'd2};
    v[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 3'd0, 16'd3};
    v[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 3'd0, 16'd3};
    v[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b1, 3'd0, 16'd3};
    v[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 3'd0, 16'd4};
    v[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd0, 16'd4};
    v[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 3'd0, 16'd4};
    v[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 16'd4};
    v[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 3'd1, 16'd4};
    @(negedge clk);
    do_reset;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_pmm_valid", 64'(pmm_valid), 64'd0);
    chk("rst_pmm_data", 64'(|pmm_data), 64'd0);
    chk("rst_pmm_control", pmm_control, 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_res_match", 64'(res_match), 64'd0);
    chk("rst_jobs_done", 64'(jobs_done), 64'd0);
    // Four 2-word jobs with every module ready, results held back by res_ready=0.
    pmm_ready = 4'hf;
    pmm_accepted = 4'h0;
    for (int i = 0; i < 17; i++) begin
      in_valid = v[i].iv;
      in_last = v[i].il;
      res_ready = v[i].rr;
      in_data = dat(i);
      in_control = 16'(i) + 16'h100;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(v[i].ir));
      chk($sformatf("tbl%0d_pmm_valid", i), 64'(pmm_valid), 64'(v[i].pv));
      chk($sformatf("tbl%0d_res_valid", i), 64'(res_valid), 64'(v[i].rv));
      chk($sformatf("tbl%0d_jobs_done", i), 64'(jobs_done), 64'(v[i].jobs));
      if (v[i].rv) begin
        chk($sformatf("tbl%0d_res_id", i), 64'(res_id), 64'(v[i].id));
        chk($sformatf("tbl%0d_res_match", i), 64'(res_match), 64'd0);
      end
      for (int k = 0; k < 4; k++)
        if (v[i].pv[k]) begin
          chk($sformatf("tbl%0d_data", i), pmm_data[k*64 +: 64], dat(i - 1));
          chk($sformatf("tbl%0d_ctrl", i), 64'(pmm_control[k*16 +: 16]), 64'(16'(i - 1) + 16'h100));
        end
      step;
    end
    // First word of a new job to module 0 has transferred; stall it, then reset mid-job.
    #1;
    chk("mid_first_word", 64'(pmm_valid), 64'd1);
    pmm_ready = 4'b1110;
    #1;
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    step;
    #1;
    chk("stall_in_ready2", 64'(in_ready), 64'd0);
    chk("stall_pmm_valid", 64'(pmm_valid), 64'd0);
    pmm_ready = 4'hf;
    #1;
    chk("unstall_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    step;
    #1;
    chk("mrst_in_ready", 64'(in_ready), 64'd0);
    chk("mrst_pmm_valid", 64'(pmm_valid), 64'd0);
    chk("mrst_pmm_data", 64'(|pmm_data), 64'd0);
    chk("mrst_pmm_control", pmm_control, 64'd0);
    chk("mrst_res_valid", 64'(res_valid), 64'd0);
    chk("mrst_res_id", 64'(res_id), 64'd0);
    chk("mrst_res_match", 64'(res_match), 64'd0);
    chk("mrst_jobs_done", 64'(jobs_done), 64'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step;
      #1;
      chk("mrst_no_strobe", 64'(pmm_valid), 64'd0);
      chk("mrst_no_result", 64'(res_valid), 64'd0);
    end
    // Only modules 0 and 2 ready.
    do_reset;
    pmm_ready = 4'b0101;
    res_ready = 1'b1;
    xfer(64'h0A00, 1'b0, 0);
    xfer(64'h0A01, 1'b1, 0);
    xfer(64'h0B00, 1'b0, 2);
    xfer(64'h0B01, 1'b1, 2);
    chk("rr_jobs_done", 64'(jobs_done), 64'd2);
    // Single-word job to module 1, result latency and match.
    do_reset;
    pmm_ready = 4'b0010;
    pmm_accepted = 4'b0010;
    res_ready = 1'b1;
    xfer(64'h3939, 1'b1, 1);
    for (int c = 1; c < 5; c++) begin
      chk($sformatf("lat_wait%0d", c), 64'(res_valid), 64'd0);
      step;
      #1;
    end
    chk("lat_res_valid", 64'(res_valid), 64'd1);
    chk("lat_res_id", 64'(res_id), 64'd1);
    chk("lat_res_match", 64'(res_match), 64'd1);
    chk("lat_jobs_done", 64'(jobs_done), 64'd1);
    for (int c = 0; c < 6; c++) begin
      step;
      #1;
      chk("lat_no_dup", 64'(res_valid), 64'd0);
    end
    // Two ripe results held behind res_ready=0, then module 0 re-eligibility.
    do_reset;
    pmm_ready = 4'b0101;
    pmm_accepted = 4'b0100;
    xfer(64'h4000, 1'b1, 0);
    xfer(64'h4002, 1'b1, 2);
    for (int c = 0; c < 6; c++) step;
    #1;
    chk("hold_res_valid", 64'(res_valid), 64'd1);
    chk("hold_res_id", 64'(res_id), 64'd0);
    chk("hold_res_match", 64'(res_match), 64'd0);
    step;
    #1;
    chk("hold_res_id2", 64'(res_id), 64'd0);
    chk("hold_res_valid2", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    in_valid = 1'b1;
    in_last = 1'b1;
    in_data = 64'h4100;
    in_control = 16'h4100;
    step;
    #1;
    res_ready = 1'b0;
    chk("hs_res_valid_low", 64'(res_valid), 64'd0);
    chk("hs_not_yet_eligible", 64'(in_ready), 64'd0);
    step;
    #1;
    chk("hs_reeligible", 64'(in_ready), 64'd1);
    chk("hs_next_valid", 64'(res_valid), 64'd1);
    chk("hs_next_id", 64'(res_id), 64'd2);
    chk("hs_next_match", 64'(res_match), 64'd1);
    step;
    in_valid = 1'b0;
    in_last = 1'b0;
    #1;
    chk("hs_redispatch", 64'(pmm_valid), 64'd1);
    chk("hs_jobs_done", 64'(jobs_done), 64'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
